sobel_window_3x3: RTL and testbench

- Stage directly downstream of the two cascaded 128-cell line-buffer FIFOs in the Sobel edge-detection datapath.
- Each enabled cycle takes three vertically aligned pixels: the live pixel, the pixel one row back (FIFO0 output) and the pixel two rows back (FIFO1 output).
- Builds a 3x3 window from these, computes the Sobel magnitude |Gx|+|Gy| saturated to 8 bits, and emits one result per interior pixel with a valid strobe.
- Row/column counters suppress border windows and mark end of frame.

---
 rtl/sobel_pkg.sv | 27 ++
 rtl/sobel_grad_core.sv | 59 +++++
 rtl/sobel_window_3x3.sv | 132 +++++++++++++
 tb/tb_sobel_window_3x3.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sobel_pkg
//  Purpose  : Shared types and helpers for the 3x3 Sobel window datapath.
//             pixel_t : 8-bit pixel
//             grad_t  : 11-bit signed gradient (range +/-1020)
//             mag_t   : 11-bit unsigned |Gx|+|Gy| (max 2040)
//             sat8()  : clamp a magnitude to the 8-bit pixel range
//  Revision : 1.0 - initial release
// ============================================================================
package sobel_pkg;

    typedef logic        [7:0]  pixel_t;
    typedef logic signed [10:0] grad_t;
    typedef logic        [10:0] mag_t;

    localparam pixel_t PIX_MAX = 8'd255;

    function automatic pixel_t sat8(input mag_t i_mag);
        if (i_mag > mag_t'(PIX_MAX)) begin
            return PIX_MAX;
        end
        return i_mag[7:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/sobel_grad_core.sv
`default_nettype none
// ============================================================================
//  Module   : sobel_grad_core
//  Purpose  : Combinational 3x3 Sobel kernel plus the first result register.
//             Window row 0 is the oldest row, column 2 the newest column.
//  Ports    : clk, rst_n      - clock, asynchronous active-low reset
//             i_win[r][c]     - 3x3 pixel window
//             i_v0 / i_f0     - window-valid and frame-end tags
//             o_gx / o_gy     - registered signed gradients
//             o_v1 / o_f1     - tags delayed to match the gradients
//  Revision : 1.0 - initial release
// ============================================================================
module sobel_grad_core
    import sobel_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  pixel_t [2:0][2:0] i_win,
    input  logic              i_v0,
    input  logic              i_f0,
    output grad_t             o_gx,
    output grad_t             o_gy,
    output logic              o_v1,
    output logic              o_f1
);

    grad_t w_p [3][3];
    grad_t w_gx;
    grad_t w_gy;

    // Zero-extend every pixel into the signed gradient width so all sums
    // and differences are evaluated without overflow.
    for (genvar r = 0; r < 3; r++) begin : g_row
        for (genvar c = 0; c < 3; c++) begin : g_col
            assign w_p[r][c] = grad_t'({3'b000, i_win[r][c]});
        end
    end

    assign w_gx = (w_p[0][2] + w_p[1][2] + w_p[1][2] + w_p[2][2])
                - (w_p[0][0] + w_p[1][0] + w_p[1][0] + w_p[2][0]);
    assign w_gy = (w_p[2][0] + w_p[2][1] + w_p[2][1] + w_p[2][2])
                - (w_p[0][0] + w_p[0][1] + w_p[0][1] + w_p[0][2]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_gx <= '0;
            o_gy <= '0;
            o_v1 <= 1'b0;
            o_f1 <= 1'b0;
        end else begin
            o_gx <= w_gx;
            o_gy <= w_gy;
            o_v1 <= i_v0;
            o_f1 <= i_f0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sobel_window_3x3.sv
`default_nettype none
// ============================================================================
//  Module   : sobel_window_3x3
//  Purpose  : 3x3 window builder and Sobel magnitude stage fed by two
//             cascaded line-buffer FIFOs. Emits one |Gx|+|Gy| (saturated to
//             8 bits) per interior pixel, two edges after the pixel that
//             completes the window was accepted.
//  Ports    : CLK, RSTn         - clock, asynchronous active-low reset
//             Enable            - pixel valid (also shifts the line buffers)
//             DataIn            - row r pixel
//             Line1In / Line2In - row r-1 / row r-2 pixels from the FIFOs
//             DataOut           - magnitude (or 0/255 when thresholded)
//             ValidOut          - one-cycle strobe per result
//             FrameDone         - pulse with the last result of a frame
//  Macro    : SOBEL_THRESHOLD_EN - binarise the output against THRESHOLD
//  Revision : 1.0 - initial release
// ============================================================================
module sobel_window_3x3
    import sobel_pkg::*;
#(
    parameter int         WIDTH     = 128,
    parameter int         HEIGHT    = 128,
    parameter logic [7:0] THRESHOLD = 8'd64
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic       Enable,
    input  logic [7:0] DataIn,
    input  logic [7:0] Line1In,
    input  logic [7:0] Line2In,
    output logic [7:0] DataOut,
    output logic       ValidOut,
    output logic       FrameDone
);

    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT);

    logic [CW-1:0]     r_col;
    logic [RW-1:0]     r_row;
    pixel_t [2:0][2:0] r_win;
    logic              r_v0;
    logic              r_f0;

    grad_t             w_gx;
    grad_t             w_gy;
    logic              w_v1;
    logic              w_f1;
    mag_t              w_abs_gx;
    mag_t              w_abs_gy;
    pixel_t            w_sat;
    pixel_t            w_out;

    logic              w_col_last;
    logic              w_row_last;

    assign w_col_last = (r_col == CW'(WIDTH - 1));
    assign w_row_last = (r_row == RW'(HEIGHT - 1));

    // E0: position counters, window shift and validity tags. The tags are
    // rewritten every cycle so a stalled window is never reported twice.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_col <= '0;
            r_row <= '0;
            r_win <= '0;
            r_v0  <= 1'b0;
            r_f0  <= 1'b0;
        end else begin
            r_v0 <= Enable && (r_col >= CW'(2)) && (r_row >= RW'(2));
            r_f0 <= Enable && w_col_last && w_row_last;
            if (Enable) begin
                for (int r = 0; r < 3; r++) begin
                    r_win[r][0] <= r_win[r][1];
                    r_win[r][1] <= r_win[r][2];
                end
                r_win[0][2] <= Line2In;
                r_win[1][2] <= Line1In;
                r_win[2][2] <= DataIn;
                if (w_col_last) begin
                    r_col <= '0;
                    r_row <= w_row_last ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
        end
    end

    // E1: gradient kernel and its output register.
    sobel_grad_core u_grad (
        .clk   (CLK),
        .rst_n (RSTn),
        .i_win (r_win),
        .i_v0  (r_v0),
        .i_f0  (r_f0),
        .o_gx  (w_gx),
        .o_gy  (w_gy),
        .o_v1  (w_v1),
        .o_f1  (w_f1)
    );

    // E2: magnitude. Negating -1020 stays within 11 bits, and the sum of two
    // absolute values (max 2040) also fits, so no extra headroom is needed.
    assign w_abs_gx = mag_t'(w_gx[10] ? -w_gx : w_gx);
    assign w_abs_gy = mag_t'(w_gy[10] ? -w_gy : w_gy);
    assign w_sat    = sat8(w_abs_gx + w_abs_gy);

`ifdef SOBEL_THRESHOLD_EN
    assign w_out = (w_sat >= THRESHOLD) ? PIX_MAX : 8'd0;
`else
    logic w_unused_threshold;
    assign w_unused_threshold = ^THRESHOLD;
    assign w_out = w_sat;
`endif

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            DataOut   <= '0;
            ValidOut  <= 1'b0;
            FrameDone <= 1'b0;
        end else begin
            ValidOut  <= w_v1;
            FrameDone <= w_v1 && w_f1;
            if (w_v1) begin
                DataOut <= w_out;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sobel_window_3x3.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sobel_window_3x3
//  Purpose  : Directed self-checking bench for sobel_window_3x3. The line
//             buffers are modelled by driving rows r-1 / r-2 straight from
//             the test image; rows that the FIFOs would not yet hold are
//             driven with junk values.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sobel_window_3x3;

    localparam int W    = 128;
    localparam int H    = 128;
    localparam int NRES = (W - 2) * (H - 2);

    // image modes
    localparam int M_CONST  = 0;
    localparam int M_VEDGE  = 1;
    localparam int M_SINGLE = 2;

    logic       CLK = 1'b0;
    logic       RSTn = 1'b0;
    logic       Enable = 1'b0;
    logic [7:0] DataIn = '0;
    logic [7:0] Line1In = '0;
    logic [7:0] Line2In = '0;
    logic [7:0] DataOut;
    logic       ValidOut;
    logic       FrameDone;

    int n_checks = 0;
    int n_fail   = 0;

    int cyc      = 0;
    int cur_mode = M_CONST;
    int er       = 1;
    int ec       = 1;
    int nres     = 0;
    int nfd      = 0;
    int acc_cyc  = 0;
    int res_cyc  = -100;
    int cap [4];

    sobel_window_3x3 #(
        .WIDTH     (W),
        .HEIGHT    (H),
        .THRESHOLD (8'd64)
    ) dut (
        .CLK       (CLK),
        .RSTn      (RSTn),
        .Enable    (Enable),
        .DataIn    (DataIn),
        .Line1In   (Line1In),
        .Line2In   (Line2In),
        .DataOut   (DataOut),
        .ValidOut  (ValidOut),
        .FrameDone (FrameDone)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] pix(input int mode, input int r, input int c);
        case (mode)
            M_CONST: return 8'd100;
            M_VEDGE: return (c >= 64) ? 8'd200 : 8'd0;
            default: return (r == 10 && c == 10) ? 8'd20 : 8'd0;
        endcase
    endfunction

    // Hand-derived result for centre (r, c).
    function automatic int exp_val(input int mode, input int r, input int c);
        case (mode)
            M_CONST: return 0;
            M_VEDGE: return (c == 63 || c == 64) ? 255 : 0;
            default: begin
                if (r >= 9 && r <= 11 && c >= 9 && c <= 11 && !(r == 10 && c == 10)) begin
`ifdef SOBEL_THRESHOLD_EN
                    return 0;
`else
                    return 40;
`endif
                end
                return 0;
            end
        endcase
    endfunction

    // Result monitor: results arrive in raster order of interior centres.
    always @(negedge CLK) begin
        if (!RSTn) begin
            er = 1;
            ec = 1;
        end else if (ValidOut) begin
            check_val($sformatf("data(%0d,%0d)", er, ec), int'(DataOut), exp_val(cur_mode, er, ec));
            check_val($sformatf("fdone(%0d,%0d)", er, ec), int'(FrameDone),
                      (er == H - 2 && ec == W - 2) ? 1 : 0);
            if (cur_mode == M_SINGLE) begin
                if (er == 10 && ec == 11) begin cap[0] = int'(DataOut); res_cyc = cyc; end
                if (er == 11 && ec == 11) cap[1] = int'(DataOut);
                if (er == 10 && ec == 10) cap[2] = int'(DataOut);
                if (er == 9  && ec == 10) cap[3] = int'(DataOut);
            end
            nres++;
            if (FrameDone) nfd++;
            if (ec == W - 2) begin
                ec = 1;
                er = (er == H - 2) ? 1 : er + 1;
            end else begin
                ec++;
            end
        end
    end

    task automatic drive_pix(input int mode, input int r, input int c);
        DataIn  = pix(mode, r, c);
        Line1In = (r >= 1) ? pix(mode, r - 1, c) : 8'hA5;
        Line2In = (r >= 2) ? pix(mode, r - 2, c) : 8'h5A;
        Enable  = 1'b1;
        @(posedge CLK);
        #1;
        Enable  = 1'b0;
    endtask

    // Drives one frame; stops after pixel (stop_r, stop_c) if it lies inside.
    task automatic send_frame(input int mode, input bit gaps, input int stop_r, input int stop_c);
        int k;
        k = 0;
        cur_mode = mode;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                drive_pix(mode, r, c);
                if (r == 11 && c == 12) acc_cyc = cyc;
                if (r == stop_r && c == stop_c) return;
                k++;
                if (gaps && (k % 7 == 0)) begin
                    repeat (5) @(posedge CLK);
                    #1;
                end
            end
        end
    endtask

    task automatic full_frame(input string name, input int mode, input bit gaps);
        int base_r;
        int base_f;
        base_r = nres;
        base_f = nfd;
        send_frame(mode, gaps, -1, -1);
        repeat (4) @(posedge CLK);
        #1;
        check_val({name, "_count"}, nres - base_r, NRES);
        check_val({name, "_framedone"}, nfd - base_f, 1);
    endtask

    task automatic single_checks(input string name);
`ifdef SOBEL_THRESHOLD_EN
        check_val({name, "_c10_11"}, cap[0], 0);
        check_val({name, "_c11_11"}, cap[1], 0);
`else
        check_val({name, "_c10_11"}, cap[0], 40);
        check_val({name, "_c11_11"}, cap[1], 40);
`endif
        check_val({name, "_c10_10"}, cap[2], 0);
`ifdef SOBEL_THRESHOLD_EN
        check_val({name, "_c9_10"}, cap[3], 0);
`else
        check_val({name, "_c9_10"}, cap[3], 40);
`endif
    endtask

    initial begin
        // Reset state
        #3;
        check_val("rst_dataout", int'(DataOut), 0);
        check_val("rst_validout", int'(ValidOut), 0);
        check_val("rst_framedone", int'(FrameDone), 0);
        repeat (2) @(posedge CLK);
        #1;
        RSTn = 1'b1;
        @(posedge CLK);
        #1;
        check_val("idle_validout", int'(ValidOut), 0);

        // Vertical edge frame aborted by reset mid-row 50
        send_frame(M_VEDGE, 1'b0, 50, 66);
        check_val("pre_rst_validout", int'(ValidOut), 1);
        check_val("pre_rst_dataout", int'(DataOut), 255);
        #1;
        RSTn = 1'b0;
        #1;
        check_val("async_rst_dataout", int'(DataOut), 0);
        check_val("async_rst_validout", int'(ValidOut), 0);
        check_val("async_rst_framedone", int'(FrameDone), 0);
        @(posedge CLK);
        #1;
        RSTn = 1'b1;

        // Fresh frame after reset: vertical edge
        full_frame("vedge", M_VEDGE, 1'b0);

        // Constant image
        full_frame("const", M_CONST, 1'b0);

        // Single pixel, gapless, with latency check
        for (int i = 0; i < 4; i++) cap[i] = -1;
        res_cyc = -100;
        full_frame("single", M_SINGLE, 1'b0);
        single_checks("single");
        check_val("latency", res_cyc - acc_cyc, 2);

        // Same image with 5-cycle gaps after every 7 pixels
        for (int i = 0; i < 4; i++) cap[i] = -1;
        full_frame("gap", M_SINGLE, 1'b1);
        single_checks("gap");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
